// File: rtl/bip_pkg.sv
// Shared constants for the BIP control unit: opcodes, datapath mux codes,
// FSM encodings and the decoder's output bundle.
package bip_pkg;

    localparam int OP_HLT  = 0;
    localparam int OP_STO  = 1;
    localparam int OP_LD   = 2;
    localparam int OP_LDI  = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_ADDI = 5;
    localparam int OP_SUB  = 6;
    localparam int OP_SUBI = 7;
    localparam int OP_JMP  = 8;
    localparam int OP_BEQZ = 9;

    localparam logic [1:0] SEL_A_RAM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef struct packed {
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op_code;
        logic       wr_acc;
        logic       wr_ram;
        logic       rd_ram;
        logic       is_mem_rd;
        logic       is_branch;
        logic       is_cond;
        logic       is_halt;
        logic       is_illegal;
    } dec_t;

endpackage

// File: rtl/bip_decoder.sv
// Purely combinational opcode decode; the top qualifies these raw controls
// with FSM state, enable and reset.
module bip_decoder
    import bip_pkg::*;
#(
    parameter int NB_OPCODE = 5
) (
    input  logic [NB_OPCODE-1:0] opcode,
    output dec_t                 dec
);

    always_comb begin
        dec = '0;
        case (opcode)
            NB_OPCODE'(OP_HLT): dec.is_halt = 1'b1;
            NB_OPCODE'(OP_STO): dec.wr_ram  = 1'b1;
            NB_OPCODE'(OP_LD): begin
                dec.sel_a     = SEL_A_RAM;
                dec.wr_acc    = 1'b1;
                dec.rd_ram    = 1'b1;
                dec.is_mem_rd = 1'b1;
            end
            NB_OPCODE'(OP_LDI): begin
                dec.sel_a  = SEL_A_IMM;
                dec.wr_acc = 1'b1;
            end
            NB_OPCODE'(OP_ADD), NB_OPCODE'(OP_SUB): begin
                dec.sel_a     = SEL_A_ALU;
                dec.sel_b     = 1'b0;
                dec.op_code   = (opcode == NB_OPCODE'(OP_SUB)) ? ALU_SUB : ALU_ADD;
                dec.wr_acc    = 1'b1;
                dec.rd_ram    = 1'b1;
                dec.is_mem_rd = 1'b1;
            end
            NB_OPCODE'(OP_ADDI), NB_OPCODE'(OP_SUBI): begin
                dec.sel_a   = SEL_A_ALU;
                dec.sel_b   = 1'b1;
                dec.op_code = (opcode == NB_OPCODE'(OP_SUBI)) ? ALU_SUB : ALU_ADD;
                dec.wr_acc  = 1'b1;
            end
            NB_OPCODE'(OP_JMP):  dec.is_branch = 1'b1;
            NB_OPCODE'(OP_BEQZ): begin
                dec.is_branch = 1'b1;
                dec.is_cond   = 1'b1;
            end
            default: dec.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bip_ctrl_unit.sv
// BIP control unit: PC sequencing, branches, RUN/WAIT/HALT FSM for multi-cycle
// RAM loads, sticky illegal-opcode flag and saturating cycle counter.
module bip_ctrl_unit
    import bip_pkg::*;
#(
    parameter int NB_DATA       = 16,
    parameter int NB_OPCODE     = 5,
    parameter int NB_OPERAND    = 11,
    parameter int LOG2_N_INSMEM = 11,
    parameter int LOG2_N_DATA   = 10,
    parameter int RAM_RD_LAT    = 1,
    parameter int NB_CYCLES     = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_valid,
    input  logic                     i_start,
    input  logic [NB_DATA-1:0]       i_instruction,
    input  logic                     i_acc_zero,
    output logic [LOG2_N_INSMEM-1:0] o_pc,
    output logic [LOG2_N_DATA-1:0]   o_data_addr,
    output logic [NB_OPERAND-1:0]    o_operand,
    output logic [1:0]               o_sel_a,
    output logic                     o_sel_b,
    output logic                     o_op_code,
    output logic                     o_wr_acc,
    output logic                     o_wr_ram,
    output logic                     o_rd_ram,
    output logic                     o_halted,
    output logic                     o_illegal,
    output logic [NB_CYCLES-1:0]     o_cycle_count
);

    // Wait counter preload: remaining WAIT cycles after the first RUN cycle.
    localparam int         WAIT_INIT_I = (RAM_RD_LAT > 0) ? RAM_RD_LAT - 1 : 0;
    localparam logic [1:0] WAIT_INIT   = WAIT_INIT_I[1:0];

    logic [1:0]               state_reg, state_next;
    logic [LOG2_N_INSMEM-1:0] pc_reg, pc_next;
    logic [1:0]               wait_cnt_reg, wait_cnt_next;
    logic                     illegal_reg, illegal_next;
    logic [NB_CYCLES-1:0]     cycle_reg, cycle_next;

    logic [NB_OPCODE-1:0]     opcode;
    logic [NB_OPERAND-1:0]    operand;
    logic [LOG2_N_INSMEM-1:0] pc_inc;
    logic [LOG2_N_INSMEM-1:0] branch_target;
    logic [NB_CYCLES-1:0]     cycle_inc;
    logic                     active;
    logic                     mem_done;
    dec_t                     dec;

    assign opcode        = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign operand       = i_instruction[NB_OPERAND-1:0];
    assign pc_inc        = pc_reg + LOG2_N_INSMEM'(1);
    assign branch_target = LOG2_N_INSMEM'(operand);
    assign cycle_inc     = (&cycle_reg) ? cycle_reg : cycle_reg + NB_CYCLES'(1);

    bip_decoder #(
        .NB_OPCODE (NB_OPCODE)
    ) u_decoder (
        .opcode (opcode),
        .dec    (dec)
    );

    // Reset is folded in so strobes drop the instant reset asserts, not at the next edge.
    assign active   = i_valid & i_reset & (state_reg != ST_HALT);
    assign mem_done = (state_reg == ST_WAIT) ? (wait_cnt_reg == 2'd0) : (RAM_RD_LAT == 0);

    assign o_sel_a   = active ? dec.sel_a : 2'd0;
    assign o_sel_b   = active & dec.sel_b;
    assign o_op_code = active & dec.op_code;
    assign o_wr_ram  = active & dec.wr_ram;
    assign o_rd_ram  = active & dec.rd_ram;
    assign o_wr_acc  = active & dec.wr_acc & (~dec.is_mem_rd | mem_done);

    assign o_pc          = pc_reg;
    assign o_data_addr   = operand[LOG2_N_DATA-1:0];
    assign o_operand     = operand;
    assign o_halted      = (state_reg == ST_HALT);
    assign o_illegal     = illegal_reg;
    assign o_cycle_count = cycle_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        wait_cnt_next = wait_cnt_reg;
        illegal_next  = illegal_reg;
        cycle_next    = cycle_reg;
        if (i_valid) begin
            case (state_reg)
                ST_RUN: begin
                    cycle_next = cycle_inc;
                    if (dec.is_illegal) begin
                        state_next   = ST_HALT;
                        illegal_next = 1'b1;
                    end else if (dec.is_halt) begin
                        state_next = ST_HALT;
                    end else if (dec.is_mem_rd) begin
                        if (RAM_RD_LAT == 0) begin
                            pc_next = pc_inc;
                        end else begin
                            state_next    = ST_WAIT;
                            wait_cnt_next = WAIT_INIT;
                        end
                    end else if (dec.is_branch) begin
                        pc_next = (!dec.is_cond || i_acc_zero) ? branch_target : pc_inc;
                    end else begin
                        pc_next = pc_inc;
                    end
                end
                ST_WAIT: begin
                    cycle_next = cycle_inc;
                    if (wait_cnt_reg == 2'd0) begin
                        state_next = ST_RUN;
                        pc_next    = pc_inc;
                    end else begin
                        wait_cnt_next = wait_cnt_reg - 2'd1;
                    end
                end
                ST_HALT: begin
                    if (i_start) begin
                        state_next   = ST_RUN;
                        pc_next      = '0;
                        illegal_next = 1'b0;
                        cycle_next   = '0;
                    end
                end
                default: state_next = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg    <= ST_RUN;
            pc_reg       <= '0;
            wait_cnt_reg <= 2'd0;
            illegal_reg  <= 1'b0;
            cycle_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            wait_cnt_reg <= wait_cnt_next;
            illegal_reg  <= illegal_next;
            cycle_reg    <= cycle_next;
        end
    end

endmodule

// File: tb/tb_bip_ctrl_unit.sv
// Scoreboarded bench for bip_ctrl_unit: directed programs queue expected per-cycle
// observations; a negedge monitor pops and compares them.
module tb_bip_ctrl_unit;

    localparam logic [6:0] C_NONE   = 7'b00_0_0_000;
    localparam logic [6:0] C_LDI    = 7'b01_0_0_100;
    localparam logic [6:0] C_ADDI   = 7'b10_1_0_100;
    localparam logic [6:0] C_SUBI   = 7'b10_1_1_100;
    localparam logic [6:0] C_STO    = 7'b00_0_0_010;
    localparam logic [6:0] C_LD_RD  = 7'b00_0_0_001;
    localparam logic [6:0] C_LD_WR  = 7'b00_0_0_101;
    localparam logic [6:0] C_SUB_RD = 7'b10_0_1_001;
    localparam logic [6:0] C_SUB_WR = 7'b10_0_1_101;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_start = 1'b0;
    logic        i_acc_zero = 1'b0;
    logic [15:0] i_instruction;
    logic [10:0] o_pc;
    logic [9:0]  o_data_addr;
    logic [10:0] o_operand;
    logic [1:0]  o_sel_a;
    logic        o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_illegal;
    logic [31:0] o_cycle_count;

    logic [15:0] imem [0:2047];

    typedef struct {
        string      nm;
        int         pc;
        logic [6:0] ctl;
        logic       halted;
        logic       ill;
        int         cc;
        int         da;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    assign i_instruction = imem[o_pc];

    bip_ctrl_unit #(
        .RAM_RD_LAT (2)
    ) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_start       (i_start),
        .i_instruction (i_instruction),
        .i_acc_zero    (i_acc_zero),
        .o_pc          (o_pc),
        .o_data_addr   (o_data_addr),
        .o_operand     (o_operand),
        .o_sel_a       (o_sel_a),
        .o_sel_b       (o_sel_b),
        .o_op_code     (o_op_code),
        .o_wr_acc      (o_wr_acc),
        .o_wr_ram      (o_wr_ram),
        .o_rd_ram      (o_rd_ram),
        .o_halted      (o_halted),
        .o_illegal     (o_illegal),
        .o_cycle_count (o_cycle_count)
    );

    function automatic logic [15:0] ins(input logic [4:0] op, input logic [10:0] opd);
        return {op, opd};
    endfunction

    task automatic chk(input string nm, input string fld, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(e.nm, "pc", int'(o_pc), e.pc);
            chk(e.nm, "ctl", int'({o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram}), int'(e.ctl));
            chk(e.nm, "halted", int'(o_halted), int'(e.halted));
            chk(e.nm, "illegal", int'(o_illegal), int'(e.ill));
            if (e.cc >= 0) chk(e.nm, "cycles", int'(o_cycle_count), e.cc);
            if (e.da >= 0) chk(e.nm, "data_addr", int'(o_data_addr), e.da);
            $display("cycle %-10s pc=%0d ctl=%b halted=%0b ill=%0b cc=%0d",
                     e.nm, o_pc, {o_sel_a, o_sel_b, o_op_code, o_wr_acc, o_wr_ram, o_rd_ram},
                     o_halted, o_illegal, o_cycle_count);
        end
    end

    task automatic push(input string nm, input int pc, input logic [6:0] ctl, input logic h,
                        input logic il, input int cc, input int da);
        exp_t e;
        e.nm = nm; e.pc = pc; e.ctl = ctl; e.halted = h; e.ill = il; e.cc = cc; e.da = da;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string nm, input logic v, input logic st, input logic az,
                       input int pc, input logic [6:0] ctl, input logic h, input logic il,
                       input int cc, input int da = -1);
        @(posedge clk);
        #1;
        i_reset = 1'b1; i_valid = v; i_start = st; i_acc_zero = az;
        push(nm, pc, ctl, h, il, cc, da);
    endtask

    // Reset is asserted 1 time unit after an edge, so a synchronous reset would be caught out.
    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        i_reset = 1'b0; i_valid = 1'b1; i_start = 1'b0; i_acc_zero = 1'b0;
        push(nm, 0, C_NONE, 1'b0, 1'b0, 0, -1);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_imem();

        // LDI 5; ADDI 3; STO 7; HLT
        do_reset("rst_a");
        clear_imem();
        imem[0] = ins(3, 5); imem[1] = ins(5, 3); imem[2] = ins(1, 7); imem[3] = ins(0, 0);
        cyc("a_ldi",  1, 0, 0, 0, C_LDI,  0, 0, 0);
        cyc("a_addi", 1, 0, 0, 1, C_ADDI, 0, 0, 1);
        cyc("a_sto",  1, 0, 0, 2, C_STO,  0, 0, 2, 7);
        cyc("a_hlt",  1, 0, 0, 3, C_NONE, 0, 0, 3);
        cyc("a_halt0",1, 0, 0, 3, C_NONE, 1, 0, 4);
        cyc("a_halt1",1, 0, 0, 3, C_NONE, 1, 0, 4);

        // LD 10 with two-cycle RAM latency
        do_reset("rst_b");
        clear_imem();
        imem[0] = ins(2, 10); imem[1] = ins(0, 0);
        cyc("b_ld0",  1, 0, 0, 0, C_LD_RD, 0, 0, 0, 10);
        cyc("b_ld1",  1, 0, 0, 0, C_LD_RD, 0, 0, 1, 10);
        cyc("b_ld2",  1, 0, 0, 0, C_LD_WR, 0, 0, 2, 10);
        cyc("b_hlt",  1, 0, 0, 1, C_NONE,  0, 0, 3);
        cyc("b_halt", 1, 0, 0, 1, C_NONE,  1, 0, 4);

        // BEQZ taken, BEQZ not taken, JMP 2047, ADDI wraps pc to 0, then freeze
        do_reset("rst_c");
        clear_imem();
        imem[0] = ins(9, 20); imem[20] = ins(9, 100); imem[21] = ins(8, 2047); imem[2047] = ins(5, 1);
        cyc("c_beqz1", 1, 0, 1, 0,    C_NONE, 0, 0, 0);
        cyc("c_beqz0", 1, 0, 0, 20,   C_NONE, 0, 0, 1);
        cyc("c_jmp",   1, 0, 0, 21,   C_NONE, 0, 0, 2);
        cyc("c_addi",  1, 0, 0, 2047, C_ADDI, 0, 0, 3);
        cyc("c_wrap",  0, 0, 0, 0,    C_NONE, 0, 0, 4);
        cyc("c_frz",   0, 0, 0, 0,    C_NONE, 0, 0, 4);

        // Illegal opcode 15, restart from HALT, start ignored while running or disabled
        do_reset("rst_d");
        clear_imem();
        imem[0] = ins(3, 1); imem[1] = ins(15, 0); imem[2] = ins(7, 4);
        cyc("d_ldi",   1, 0, 0, 0, C_LDI,  0, 0, 0);
        cyc("d_ill",   1, 0, 0, 1, C_NONE, 0, 0, 1);
        cyc("d_start", 1, 1, 0, 1, C_NONE, 1, 1, 2);
        cyc("d_rerun", 1, 1, 0, 0, C_LDI,  0, 0, 0);
        cyc("d_ill2",  1, 0, 0, 1, C_NONE, 0, 0, 1);
        cyc("d_nostrt",0, 1, 0, 1, C_NONE, 1, 1, 2);
        cyc("d_hold",  1, 0, 0, 1, C_NONE, 1, 1, 2);

        // SUBI then SUB with i_valid low for 4 cycles in the middle of WAIT
        do_reset("rst_e");
        clear_imem();
        imem[0] = ins(7, 4); imem[1] = ins(6, 9); imem[2] = ins(0, 0);
        cyc("e_subi",  1, 0, 0, 1 - 1, C_SUBI,   0, 0, 0);
        cyc("e_sub0",  1, 0, 0, 1,     C_SUB_RD, 0, 0, 1, 9);
        for (int k = 0; k < 4; k++)
            cyc("e_frz",  0, 0, 0, 1,  C_NONE,   0, 0, 2);
        cyc("e_sub1",  1, 0, 0, 1,     C_SUB_RD, 0, 0, 2, 9);
        cyc("e_sub2",  1, 0, 0, 1,     C_SUB_WR, 0, 0, 3, 9);
        cyc("e_hlt",   1, 0, 0, 2,     C_NONE,   0, 0, 4);
        cyc("e_halt",  1, 0, 0, 2,     C_NONE,   1, 0, 5);

        // Asynchronous reset in the middle of WAIT
        do_reset("rst_f");
        clear_imem();
        imem[0] = ins(3, 7); imem[1] = ins(2, 3);
        cyc("f_ldi",  1, 0, 0, 0, C_LDI,   0, 0, 0);
        cyc("f_ld0",  1, 0, 0, 1, C_LD_RD, 0, 0, 1, 3);
        cyc("f_ld1",  1, 0, 0, 1, C_LD_RD, 0, 0, 2, 3);
        do_reset("f_arst");
        cyc("f_ldi2", 1, 0, 0, 0, C_LDI,   0, 0, 0);
        cyc("f_ld2",  1, 0, 0, 1, C_LD_RD, 0, 0, 1, 3);

        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("end", "queue_left", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
